seg_bin2bcd: RTL and testbench

Sequential binary-to-BCD converter feeding the six-digit seven-segment display driver. Accepts a 20-bit unsigned value over a valid/ready handshake, converts it with an iterative shift-and-add-3 (double dabble) over 20 cycles, and presents six packed BCD digits plus an overflow flag. The display driver therefore needs no dividers; it only selects nibbles.

---
 rtl/seg_bin2bcd_pkg.sv | 18 +
 rtl/seg_bin2bcd_add3.sv | 9 +
 rtl/seg_bin2bcd.sv | 86 ++++++++
 tb/tb_seg_bin2bcd.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/seg_bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package seg_bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int BIN_W      = 20;
  localparam int DIGITS     = 6;
  localparam int INT_DIGITS = 7;
  localparam int CNT_W      = 5;

  localparam logic [DIGITS*4-1:0] BCD_MAX    = 24'h999999;
  localparam logic [CNT_W-1:0]    LAST_SHIFT = 5'd19;

endpackage

// File: rtl/seg_bin2bcd_add3.sv
// Double-dabble nibble correction: adds 3 to any digit of 5 or more before the shift.
module bcd_add3 (
  input  logic [3:0] nib,
  output logic [3:0] adj
);

  assign adj = (nib >= 4'd5) ? nib + 4'd3 : nib;

endmodule

// File: rtl/seg_bin2bcd.sv
// 20-bit binary to six-digit packed BCD, one shift-and-add-3 step per cycle,
// with optional clamping of out-of-range values to 999999.
module seg_bin2bcd
  import seg_bin2bcd_pkg::*;
#(
  parameter bit CLAMP = 1'b1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BIN_W-1:0]    in_data,
  output logic [DIGITS*4-1:0] out_bcd,
  output logic                out_valid,
  output logic                out_ovf
);

  state_t                     state;
  state_t                     next_state;
  logic [BIN_W-1:0]           bin_sh;
  logic [INT_DIGITS*4-1:0]    bcd_sh;
  logic [INT_DIGITS*4-1:0]    bcd_adj;
  logic [CNT_W-1:0]           cnt;
  logic                       ovf;

  // One correction cell per internal digit, all applied in the same cycle.
  for (genvar i = 0; i < INT_DIGITS; i++) begin : g_add3
    bcd_add3 u_add3 (
      .nib (bcd_sh[4*i +: 4]),
      .adj (bcd_adj[4*i +: 4])
    );
  end

  assign in_ready = (state == IDLE);
  assign ovf      = (bcd_sh[INT_DIGITS*4-1 -: 4] != 4'd0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid)            next_state = CONV;
      CONV:    if (cnt == LAST_SHIFT)   next_state = DONE;
      DONE:                             next_state = IDLE;
      default:                          next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bin_sh    <= '0;
      bcd_sh    <= '0;
      cnt       <= '0;
      out_bcd   <= '0;
      out_ovf   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            bin_sh <= in_data;
            bcd_sh <= '0;
            cnt    <= '0;
          end
        end
        CONV: begin
          {bcd_sh, bin_sh} <= {bcd_adj, bin_sh} << 1;
          cnt              <= cnt + 5'd1;
        end
        DONE: begin
          // The seventh digit only exists to detect values above 999999.
          if (CLAMP && ovf) out_bcd <= BCD_MAX;
          else              out_bcd <= bcd_sh[DIGITS*4-1:0];
          out_ovf   <= ovf;
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_bin2bcd.sv
// Bench for seg_bin2bcd: clamping and pass-through variants run side by side on one stimulus.
module tb_seg_bin2bcd;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic [19:0] in_data;

  logic        in_ready_c, out_valid_c, out_ovf_c;
  logic [23:0] out_bcd_c;
  logic        in_ready_w, out_valid_w, out_ovf_w;
  logic [23:0] out_bcd_w;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  seg_bin2bcd #(.CLAMP(1'b1)) dut_clamp (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready_c),
    .in_data   (in_data),
    .out_bcd   (out_bcd_c),
    .out_valid (out_valid_c),
    .out_ovf   (out_ovf_c)
  );

  seg_bin2bcd #(.CLAMP(1'b0)) dut_wrap (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready_w),
    .in_data   (in_data),
    .out_bcd   (out_bcd_w),
    .out_valid (out_valid_w),
    .out_ovf   (out_ovf_w)
  );

  // Reference: decimal digits by repeated division.
  function automatic logic [23:0] to_bcd(input int unsigned v);
    logic [23:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkResult(input int unsigned v);
    logic [23:0] exp_c, exp_w;
    exp_c = (v > 999999) ? 24'h999999 : to_bcd(v);
    exp_w = to_bcd(v % 1000000);
    checkOutput($sformatf("bcd_clamp(%0d)", v), {8'd0, out_bcd_c}, {8'd0, exp_c});
    checkOutput($sformatf("bcd_wrap(%0d)", v),  {8'd0, out_bcd_w}, {8'd0, exp_w});
    checkOutput($sformatf("ovf_clamp(%0d)", v), {31'd0, out_ovf_c}, {31'd0, v > 999999});
    checkOutput($sformatf("ovf_wrap(%0d)", v),  {31'd0, out_ovf_w}, {31'd0, v > 999999});
  endtask

  // Cycles until out_valid, scrambling in_data meanwhile; bounded at 30.
  task automatic waitResult(output int lat);
    lat = 0;
    while (lat < 30 && !out_valid_c) begin
      @(posedge clk); #1;
      lat++;
      if (!out_valid_c) in_data = 20'($urandom);
    end
  endtask

  task automatic applyStimulus(input logic [19:0] v);
    int n = 0;
    while (!in_ready_c && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b1;
    in_data  = v;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 20'($urandom);
    checkOutput("ready_low_after_accept", {31'd0, in_ready_c}, 32'd0);
  endtask

  task automatic convertAndCheck(input int unsigned v);
    int lat;
    applyStimulus(20'(v));
    waitResult(lat);
    checkOutput($sformatf("latency(%0d)", v), lat, 21);
    checkOutput("valid_wrap", {31'd0, out_valid_w}, 32'd1);
    checkResult(v);
    checkOutput("ready_at_result", {31'd0, in_ready_c}, 32'd1);
    @(posedge clk); #1;
    checkOutput("valid_one_cycle", {31'd0, out_valid_c}, 32'd0);
  endtask

  initial begin
    int lat;
    int seen;
    int unsigned v;

    resetn   = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    checkOutput("reset_bcd",   {8'd0, out_bcd_c},    32'd0);
    checkOutput("reset_valid", {31'd0, out_valid_c}, 32'd0);
    checkOutput("reset_ovf",   {31'd0, out_ovf_c},   32'd0);
    checkOutput("reset_ready", {31'd0, in_ready_c},  32'd1);
    checkOutput("reset_ready_wrap", {31'd0, in_ready_w}, 32'd1);
    @(posedge clk); #1;

    $display("[TB] directed values");
    convertAndCheck(123456);
    convertAndCheck(0);
    convertAndCheck(9);
    convertAndCheck(10);
    convertAndCheck(99999);
    convertAndCheck(999999);
    convertAndCheck(1000000);
    convertAndCheck(20'hFFFFF);

    $display("[TB] random values");
    for (int i = 0; i < 16; i++) begin
      if (i % 4 == 0) v = 999998 + $urandom_range(0, 3);
      else            v = $urandom_range(0, 1048575);
      convertAndCheck(v);
    end

    $display("[TB] back-to-back");
    in_valid = 1'b1;
    in_data  = 20'd1;
    @(posedge clk); #1;
    for (int k = 1; k <= 21; k++) begin
      if (k < 21) in_data = 20'($urandom);
      if (k < 21) begin @(posedge clk); #1; end
      else        begin @(posedge clk); #1; end
    end
    checkOutput("b2b_first_valid", {31'd0, out_valid_c}, 32'd1);
    checkResult(1);
    in_data = 20'd654321;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 20'($urandom);
    checkOutput("b2b_second_accepted", {31'd0, in_ready_c}, 32'd0);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("b2b_hold_old", {8'd0, out_bcd_c}, 32'h000001);
    waitResult(lat);
    checkOutput("b2b_latency", lat + 10, 21);
    checkResult(654321);

    $display("[TB] reset mid-conversion");
    applyStimulus(20'd777777);
    repeat (4) @(posedge clk);
    #1 resetn = 1'b0;
    #1;
    checkOutput("midreset_bcd",   {8'd0, out_bcd_c},    32'd0);
    checkOutput("midreset_valid", {31'd0, out_valid_c}, 32'd0);
    checkOutput("midreset_ready", {31'd0, in_ready_c},  32'd1);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    seen = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (out_valid_c || out_valid_w) seen = 1;
    end
    checkOutput("midreset_no_pulse", seen, 0);
    convertAndCheck(42);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
